// File: rtl/ex_multu_unit.sv
// Iterative shift-add WIDTH x WIDTH multiplier for the EX stage; owns HI/LO and stalls on hazards.
// Define MULT_SIGNED_EN to also accept signed mult (Funct 24) via magnitude/negate wrapping.
module ex_multu_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             flush_in,
  input  logic [5:0]       opcode_in,
  input  logic [5:0]       funct_in,
  input  logic [WIDTH-1:0] rs_val_in,
  input  logic [WIDTH-1:0] rt_val_in,
  output logic             busy_out,
  output logic             stall_out,
  output logic             done_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] mf_data_out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [5:0] FunctMfhi  = 6'd16;
  localparam logic [5:0] FunctMflo  = 6'd18;
  localparam logic [5:0] FunctMultu = 6'd25;
`ifdef MULT_SIGNED_EN
  localparam logic [5:0] FunctMult  = 6'd24;
`endif

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]     prod_q, prod_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 qual;
  logic                 is_mul;
  logic                 is_mfhi;
  logic                 is_mflo;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [WIDTH:0]       upper_sum;
  logic [2*WIDTH:0]     prod_shift;
  logic [2*WIDTH-1:0]   result;

  assign qual    = valid_in & ~flush_in & (opcode_in == 6'd0);
  assign is_mfhi = qual & (funct_in == FunctMfhi);
  assign is_mflo = qual & (funct_in == FunctMflo);

`ifdef MULT_SIGNED_EN
  logic is_mult;
  logic sign_q, sign_d;

  assign is_mult = qual & (funct_in == FunctMult);
  assign is_mul  = is_mult | (qual & (funct_in == FunctMultu));
  // Signed mult runs the unsigned datapath on magnitudes; the sign is reapplied at completion.
  assign op_a    = (is_mult & rs_val_in[WIDTH-1]) ? (~rs_val_in + WIDTH'(1)) : rs_val_in;
  assign op_b    = (is_mult & rt_val_in[WIDTH-1]) ? (~rt_val_in + WIDTH'(1)) : rt_val_in;
  assign result  = sign_q ? (~prod_shift[2*WIDTH-1:0] + (2*WIDTH)'(1))
                          : prod_shift[2*WIDTH-1:0];
`else
  assign is_mul  = qual & (funct_in == FunctMultu);
  assign op_a    = rs_val_in;
  assign op_b    = rt_val_in;
  assign result  = prod_shift[2*WIDTH-1:0];
`endif

  // Upper half is WIDTH+1 bits wide so the add carry survives into the shift.
  assign upper_sum  = prod_q[2*WIDTH:WIDTH] + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_shift = {1'b0, upper_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULT_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (is_mul) begin
          state_d = StBusy;
          cnt_d   = '0;
          prod_d  = {{(WIDTH+1){1'b0}}, op_b};
          mcand_d = op_a;
`ifdef MULT_SIGNED_EN
          sign_d  = is_mult & (rs_val_in[WIDTH-1] ^ rt_val_in[WIDTH-1]);
`endif
        end
      end
      StBusy: begin
        if (flush_in) begin
          state_d = StIdle;
        end else begin
          prod_d = prod_shift;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            hi_d    = result[2*WIDTH-1:WIDTH];
            lo_d    = result[WIDTH-1:0];
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StBusy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MULT_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign stall_out   = busy_q & (is_mul | is_mfhi | is_mflo);
  assign mf_data_out = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);

endmodule

// File: tb/tb_ex_multu_unit.sv
// Directed self-checking bench for ex_multu_unit: latency, hazards, back-to-back, reset and flush.
module tb_ex_multu_unit;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             valid_in;
  logic             flush_in;
  logic [5:0]       opcode_in;
  logic [5:0]       funct_in;
  logic [WIDTH-1:0] rs_val_in;
  logic [WIDTH-1:0] rt_val_in;
  logic             busy_out;
  logic             stall_out;
  logic             done_out;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic [WIDTH-1:0] mf_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  ex_multu_unit #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .flush_in    (flush_in),
    .opcode_in   (opcode_in),
    .funct_in    (funct_in),
    .rs_val_in   (rs_val_in),
    .rt_val_in   (rt_val_in),
    .busy_out    (busy_out),
    .stall_out   (stall_out),
    .done_out    (done_out),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .mf_data_out (mf_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    valid_in  = v;
    opcode_in = 6'd0;
    funct_in  = f;
    rs_val_in = a;
    rt_val_in = b;
  endtask

  task automatic idle_in();
    set_in(1'b0, 6'd0, 32'd0, 32'd0);
  endtask

  // Present an op for one edge, then drop to a bubble.
  task automatic start_mul(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    set_in(1'b1, f, a, b);
    @(negedge clk);
    idle_in();
  endtask

  // Walk cycles until done_out, counting busy and stall cycles; bounded.
  task automatic wait_done(output int bc, output int sc, output bit seen);
    bc = 0;
    sc = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (done_out) begin
        seen = 1'b1;
        break;
      end
      if (busy_out) bc++;
      if (stall_out) sc++;
      @(negedge clk);
    end
  endtask

  task automatic watch_no_done(input int cycles, output bit any_done);
    any_done = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done_out) any_done = 1'b1;
    end
  endtask

  int bc;
  int sc;
  bit seen;

  initial begin
    rst      = 1'b1;
    flush_in = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy_out, 0);
    check_eq("rst_done", done_out, 0);
    check_eq("rst_hilo", {hi_out, lo_out}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic 3 x 5
    start_mul(6'd25, 32'd3, 32'd5);
    wait_done(bc, sc, seen);
    check_eq("basic_done", seen, 1);
    check_eq("basic_busy_cycles", bc, 32);
    check_eq("basic_hilo", {hi_out, lo_out}, 64'd15);
    @(negedge clk);
    #1;
    check_eq("basic_done_pulse", done_out, 0);
    set_in(1'b1, 6'd18, 32'd0, 32'd0);
    #1;
    check_eq("mflo_data", mf_data_out, 32'h0000000F);
    check_eq("mflo_stall", stall_out, 0);
    @(negedge clk);
    idle_in();

    // Maximum operands, then a second run accepted in the DONE cycle
    start_mul(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(bc, sc, seen);
    check_eq("max_hilo", {hi_out, lo_out}, 64'hFFFFFFFE_00000001);
    start_mul(6'd25, 32'h80000000, 32'd2);
    wait_done(bc, sc, seen);
    check_eq("msb_done", seen, 1);
    check_eq("msb_hilo", {hi_out, lo_out}, 64'h00000001_00000000);
    @(negedge clk);

    // mfhi right behind a multu
    start_mul(6'd25, 32'h10000, 32'h10000);
    set_in(1'b1, 6'd16, 32'd0, 32'd0);
    wait_done(bc, sc, seen);
    check_eq("mfhi_stall_cycles", sc, 32);
    check_eq("mfhi_stall_release", stall_out, 0);
    check_eq("mfhi_data", mf_data_out, 32'h00000001);
    @(negedge clk);
    idle_in();

    // Back-to-back multu: second one stalls then enters in the DONE cycle
    start_mul(6'd25, 32'd11, 32'd13);
    set_in(1'b1, 6'd25, 32'd7, 32'd6);
    wait_done(bc, sc, seen);
    check_eq("b2b_stall_cycles", sc, 32);
    check_eq("b2b_stall_release", stall_out, 0);
    check_eq("b2b_first_lo", {hi_out, lo_out}, 64'd143);
    @(negedge clk);
    idle_in();
    #1;
    check_eq("b2b_second_busy", busy_out, 1);
    wait_done(bc, sc, seen);
    check_eq("b2b_second_cycles", bc, 32);
    check_eq("b2b_second_hilo", {hi_out, lo_out}, 64'd42);
    @(negedge clk);

    // Bubble and same-cycle flush never start
    set_in(1'b0, 6'd25, 32'd9, 32'd9);
    @(negedge clk);
    #1;
    check_eq("bubble_ignored", busy_out, 0);
    set_in(1'b1, 6'd25, 32'd9, 32'd9);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    idle_in();
    #1;
    check_eq("flush_start_suppressed", busy_out, 0);

    // Reset at BUSY cycle 10
    @(negedge clk);
    start_mul(6'd25, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_busy", busy_out, 0);
    check_eq("midrst_done", done_out, 0);
    check_eq("midrst_hilo", {hi_out, lo_out}, 64'd0);
    watch_no_done(40, seen);
    check_eq("midrst_no_done", seen, 0);

    // Flush at BUSY cycle 5 keeps the earlier result
    start_mul(6'd25, 32'd3, 32'd5);
    wait_done(bc, sc, seen);
    check_eq("preflush_hilo", {hi_out, lo_out}, 64'd15);
    @(negedge clk);
    start_mul(6'd25, 32'd9, 32'd9);
    repeat (4) @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    #1;
    check_eq("flush_abort_busy", busy_out, 0);
    watch_no_done(40, seen);
    check_eq("flush_no_done", seen, 0);
    check_eq("flush_hilo_kept", {hi_out, lo_out}, 64'd15);

`ifdef MULT_SIGNED_EN
    start_mul(6'd24, 32'hFFFFFFFD, 32'd5);
    wait_done(bc, sc, seen);
    check_eq("mult_cycles", bc, 32);
    check_eq("mult_hilo", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFF1);
`else
    // Funct 24 is not a multiply here: no stall, no start
    start_mul(6'd25, 32'd3, 32'd5);
    set_in(1'b1, 6'd24, 32'hFFFFFFFD, 32'd5);
    wait_done(bc, sc, seen);
    check_eq("f24_no_stall", sc, 0);
    @(negedge clk);
    idle_in();
    #1;
    check_eq("f24_not_started", busy_out, 0);
    check_eq("f24_hilo", {hi_out, lo_out}, 64'd15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_multu_unit.md
Name: ex_multu_unit

Overview:
- Iterative 32-bit unsigned multiplier in the EX stage. Consumes opcode/Funct/RD1/RD2 from the ID/EX pipeline register and owns the architectural HI/LO registers.
- Executes multu (opcode 0, Funct 25) over WIDTH cycles and services mfhi (Funct 16) and mflo (Funct 18).
- Raises a stall to the hazard/pipeline-hold logic whenever an instruction needs HI/LO or the multiplier while an operation is still in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; latency is WIDTH iterations.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  EX-stage instruction valid (deasserted for bubbles)
- flush_in  in  1  EX-stage instruction being squashed this cycle
- opcode_in  in  6  opcode from ID/EX
- funct_in  in  6  Funct from ID/EX
- rs_val_in  in  WIDTH  RD1 from ID/EX (multiplicand)
- rt_val_in  in  WIDTH  RD2 from ID/EX (multiplier)
- busy_out  out  1  iteration in progress
- stall_out  out  1  hold IF/ID/EX stages this cycle (combinational)
- done_out  out  1  one-cycle pulse when HI/LO are updated
- hi_out  out  WIDTH  HI register
- lo_out  out  WIDTH  LO register
- mf_data_out  out  WIDTH  mfhi→HI, mflo→LO, else 0 (combinational)

Behaviour:
- Decode: is_mul = valid_in & !flush_in & opcode_in==0 & funct_in==25. is_mf = the same qualifiers with funct_in==16 or 18.
- Reset: state=IDLE; counter, HI, LO and product register cleared; busy_out=0, done_out=0. Reset overrides everything, including an operation in progress.
- States:
  - IDLE: is_mul → BUSY, counter=0. Product P (2*WIDTH+1 bits) loaded as {0, rt_val_in}; multiplicand register loaded with rs_val_in.
  - BUSY: each edge, if P[0] then P[2W:W] += multiplicand. Then P is shifted right by 1. Counter increments.
  - When counter reaches WIDTH-1: {HI,LO} <= the final shifted P[2W-1:0]; state → DONE; done_out=1 next cycle.
  - DONE: lasts one cycle. Behaves exactly as IDLE, so an is_mul here is accepted with no bubble.
- Latency: start sampled at edge E0; HI/LO updated at edge E(WIDTH). busy_out is 1 from after E0 through E(WIDTH).
- stall_out = busy_out & (is_mul | is_mf).
  - A new multu or an mfhi/mflo arriving during BUSY stalls.
  - It is released in the DONE cycle.
  - A stalled multu is not accepted until stall_out falls.
- HI/LO change only at completion. They hold their prior value throughout BUSY.
- mf_data_out reads the current HI/LO. It is only meaningful when stall_out=0.
- flush_in:
  - Same cycle as a start: the start is suppressed.
  - During BUSY: the operation aborts (state → IDLE, no done_out, HI/LO unchanged). The flush applies to the whole EX-stage pipeline, so it also covers the multu's own squash.
- A multu whose valid_in is low (bubble) is ignored.
- Products wrap nothing: the full 2*WIDTH-bit result is kept.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined: additionally accepts mult (Funct 24).
  - Operands are converted to magnitudes at start and the sign (rs[W-1]^rt[W-1]) is latched.
  - The 2W-bit result is two's-complement negated at completion when the sign is set.
  - Latency, stall and flush behaviour are identical to multu.
- Undefined: Funct 24 is not decoded as a multiply and does not stall. There is no sign logic.

Test Plan:
- Basic multu: multu rs=3, rt=5. busy_out high for 32 cycles, then done_out pulses once; HI=0x00000000, LO=0x0000000F. The following mflo gives mf_data_out=0x0000000F.
- Maximum operands: multu 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. A second run of 0x80000000 × 2 → HI=0x00000001, LO=0.
- mfhi hazard: multu 0x10000 × 0x10000 followed immediately by mfhi. stall_out=1 for each BUSY cycle while mfhi is in EX and drops in the DONE cycle. Then mf_data_out=0x00000001.
- Back-to-back: a second multu (7×6) arriving during BUSY stalls and is accepted in the DONE cycle. The first result is visible in that cycle. Final LO=42 after a further 32 cycles.
- Reset/flush mid-operation:
  - rst asserted at BUSY cycle 10 → next cycle busy_out=0, HI=LO=0, no done_out.
  - Separately, flush_in at cycle 5 of 9×9 after a prior result HI=0, LO=15 → HI/LO remain 0/15.
- With MULT_SIGNED_EN: mult −3 (0xFFFFFFFD) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Without the macro, Funct 24 leaves HI/LO unchanged and stall_out=0.
